// File: rtl/ffo_rr_arbiter.sv
// Round-robin find-first-one arbiter: picks the first set req_vec bit starting at ptr.
// Latency: 1 cycle from request seen (in IDLE) to grant_valid; back-to-back 1 grant/cycle.
// Backpressure: while grant_valid & !grant_ready the grant and ptr are frozen, req_vec ignored.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   req_vec           request bits, bit i = requester i
//   grant_valid/ready valid/ready handshake for the registered winner
//   grant_onehot/idx  winner as one-hot and binary index (zero while !grant_valid)
//   ptr               current highest-priority position, moves only on a handshake
// Build option: define FFO_FIXED_PRIO_EN for fixed lowest-index-first priority
// (ptr tied to 0, no one-cycle mask of the accepted requester).
module ffo_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] req_vec,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [WIDTH-1:0] grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic [IDX_W-1:0] ptr
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] onehot_next;
    logic [IDX_W-1:0] idx_next;
    logic [IDX_W-1:0] ptr_next;

    logic             handshake;
    logic [IDX_W-1:0] ptr_after;    // pointer value a handshake would load
    logic [IDX_W-1:0] search_ptr;
    logic [WIDTH-1:0] search_req;

    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic [WIDTH-1:0] win_oh;

    assign grant_valid = (state == GRANT);
    assign handshake   = grant_valid & grant_ready;

`ifdef FFO_FIXED_PRIO_EN
    assign ptr_after  = '0;
    assign search_req = req_vec;
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic [WIDTH-1:0] masked_req;

    assign ptr_after  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    // Hide the requester just accepted so it cannot win twice in a row, unless it is
    // the only one asking (then the mask would leave nothing and is dropped).
    assign masked_req = req_vec & ~grant_onehot;
    assign search_req = (handshake && (masked_req != '0)) ? masked_req : req_vec;
`endif

    // On a handshake the re-search already uses the pointer being loaded at this edge.
    assign search_ptr = handshake ? ptr_after : ptr;

    // Rotating find-first-one: scan search_ptr, search_ptr+1, ... modulo WIDTH.
    always_comb begin
        int j;
        found   = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        j       = 0;
        for (int k = 0; k < WIDTH; k++) begin
            j = int'(search_ptr) + k;
            if (j >= WIDTH) begin
                j = j - WIDTH;
            end
            if (!found && search_req[j]) begin
                found     = 1'b1;
                win_idx   = IDX_W'(j);
                win_oh[j] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        onehot_next = grant_onehot;
        idx_next    = grant_idx;
        ptr_next    = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next  = GRANT;
                    onehot_next = win_oh;
                    idx_next    = win_idx;
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    ptr_next = ptr_after;
                    if (found) begin
                        onehot_next = win_oh;
                        idx_next    = win_idx;
                    end else begin
                        state_next  = IDLE;
                        onehot_next = '0;
                        idx_next    = '0;
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                onehot_next = '0;
                idx_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            grant_onehot <= '0;
            grant_idx    <= '0;
            ptr          <= '0;
        end else begin
            state        <= state_next;
            grant_onehot <= onehot_next;
            grant_idx    <= idx_next;
            ptr          <= ptr_next;
        end
    end

endmodule

// File: tb/tb_ffo_rr_arbiter.sv
// Testbench for ffo_rr_arbiter (WIDTH=8): directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
// Works for both the default build and the FFO_FIXED_PRIO_EN build.
module tb_ffo_rr_arbiter;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] req_vec = '0;
    logic         grant_valid;
    logic         grant_ready = 1'b0;
    logic [W-1:0] grant_onehot;
    logic [2:0]   grant_idx;
    logic [2:0]   ptr;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    logic m_valid = 1'b0;
    int   m_idx   = 0;
    int   m_ptr   = 0;

    ffo_rr_arbiter #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_vec      (req_vec),
        .grant_valid  (grant_valid),
        .grant_ready  (grant_ready),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .ptr          (ptr)
    );

    always #5 clock = ~clock;

    // First set bit of s visiting p, p+1, ... wrapping modulo W.
    function automatic int first_from(input logic [W-1:0] s, input int p);
        for (int k = 0; k < W; k++) begin
            if (s[(p + k) % W]) return (p + k) % W;
        end
        return 0;
    endfunction

    // Drive inputs for one cycle, advance the model across the edge, sample 1 time unit later.
    task automatic tick(input logic [W-1:0] r, input logic rdy, input logic rst);
        logic [W-1:0] s;
        req_vec     = r;
        grant_ready = rdy;
        reset       = rst;
        if (rst) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = 0;
        end else if (!m_valid) begin
            if (r != '0) begin
                m_idx   = first_from(r, m_ptr);
                m_valid = 1'b1;
            end
        end else if (rdy) begin
`ifdef FFO_FIXED_PRIO_EN
            m_ptr = 0;
            s     = r;
`else
            m_ptr = (m_idx + 1) % W;
            s     = r & ~(8'(1) << m_idx);
            if (s == '0) s = r;
`endif
            if (s != '0) begin
                m_idx = first_from(s, m_ptr);
            end else begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 2; c++) begin
            tick(8'hFF, 1'b0, 1'b1);
            n_tests++;
            if (grant_valid !== 1'b0 || ptr !== 3'd0 || grant_onehot !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: valid=%b ptr=%0d onehot=%h, want 0/0/00",
                         c, grant_valid, ptr, grant_onehot);
            end
        end
        tick(8'hFF, 1'b0, 1'b0);
        n_tests++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || grant_onehot !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b idx=%0d onehot=%h, want 1/0/01",
                     grant_valid, grant_idx, grant_onehot);
        end
    endtask

`ifndef FFO_FIXED_PRIO_EN
    // Enters with grant idx 0, ptr 0; all requests held, consumer always ready.
    task automatic test_back_to_back;
        for (int k = 0; k < 9; k++) begin
            tick(8'hFF, 1'b1, 1'b0);
            n_tests++;
            if (grant_valid !== 1'b1 || grant_idx !== 3'((k + 1) % 8) || ptr !== 3'((k + 1) % 8)) begin
                n_fail++;
                $display("FAIL rotation step%0d: valid=%b idx=%0d ptr=%0d, want 1/%0d/%0d",
                         k, grant_valid, grant_idx, ptr, (k + 1) % 8, (k + 1) % 8);
            end
        end
        tick(8'h00, 1'b1, 1'b0);   // accept idx1, nothing left
        n_tests++;
        if (grant_valid !== 1'b0 || ptr !== 3'd2) begin
            n_fail++;
            $display("FAIL rotation_drain: valid=%b ptr=%0d, want 0/2", grant_valid, ptr);
        end
    endtask

    task automatic test_skip_wrap;
        tick(8'h20, 1'b0, 1'b0);   // grant 5
        tick(8'h00, 1'b1, 1'b0);   // accept 5 -> ptr 6, idle
        tick(8'h05, 1'b0, 1'b0);
        n_tests++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || ptr !== 3'd6) begin
            n_fail++;
            $display("FAIL wrap_grant: valid=%b idx=%0d ptr=%0d, want 1/0/6", grant_valid, grant_idx, ptr);
        end
        tick(8'h05, 1'b1, 1'b0);   // bit0 still held at accept; must not win again
        n_tests++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd2 || ptr !== 3'd1) begin
            n_fail++;
            $display("FAIL wrap_next: valid=%b idx=%0d ptr=%0d, want 1/2/1", grant_valid, grant_idx, ptr);
        end
        tick(8'h00, 1'b1, 1'b0);   // accept 2 -> ptr 3, idle
    endtask

    task automatic test_stall;
        logic [W-1:0] r;
        tick(8'h08, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            r = 8'($urandom) | 8'h08;
            tick(r, 1'b0, 1'b0);
            n_tests++;
            if (grant_valid !== 1'b1 || grant_onehot !== 8'h08 || ptr !== 3'd3) begin
                n_fail++;
                $display("FAIL stall cyc%0d: valid=%b onehot=%h ptr=%0d, want 1/08/3",
                         c, grant_valid, grant_onehot, ptr);
            end
        end
        tick(8'h00, 1'b1, 1'b0);
        n_tests++;
        if (grant_valid !== 1'b0 || ptr !== 3'd4) begin
            n_fail++;
            $display("FAIL stall_accept: valid=%b ptr=%0d, want 0/4", grant_valid, ptr);
        end
    endtask

    task automatic test_drain_idle;
        tick(8'h10, 1'b1, 1'b0);   // ready while idle is ignored
        n_tests++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd4 || ptr !== 3'd4) begin
            n_fail++;
            $display("FAIL drain_grant: valid=%b idx=%0d ptr=%0d, want 1/4/4", grant_valid, grant_idx, ptr);
        end
        for (int c = 0; c < 3; c++) begin
            tick(8'h00, 1'b1, 1'b0);
            n_tests++;
            if (grant_valid !== 1'b0 || grant_onehot !== 8'h00 || grant_idx !== 3'd0 || ptr !== 3'd5) begin
                n_fail++;
                $display("FAIL drain_idle cyc%0d: valid=%b onehot=%h idx=%0d ptr=%0d, want 0/00/0/5",
                         c, grant_valid, grant_onehot, grant_idx, ptr);
            end
        end
    endtask
`else
    // Enters with grant idx 0, ptr 0.
    task automatic test_fixed_prio;
        for (int c = 0; c < 4; c++) begin
            tick(8'hA1, 1'b1, 1'b0);
            n_tests++;
            if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || ptr !== 3'd0) begin
                n_fail++;
                $display("FAIL fixed_bit0 cyc%0d: valid=%b idx=%0d ptr=%0d, want 1/0/0",
                         c, grant_valid, grant_idx, ptr);
            end
        end
        tick(8'hA0, 1'b1, 1'b0);
        n_tests++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd5 || ptr !== 3'd0) begin
            n_fail++;
            $display("FAIL fixed_next: valid=%b idx=%0d ptr=%0d, want 1/5/0", grant_valid, grant_idx, ptr);
        end
        tick(8'h00, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_reset_in_grant;
        tick(8'hFF, 1'b0, 1'b0);
        n_tests++;
        if (grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rig_pre: valid=%b, want 1", grant_valid);
        end
        tick(8'hFF, 1'b1, 1'b1);
        n_tests++;
        if (grant_valid !== 1'b0 || ptr !== 3'd0 || grant_onehot !== 8'h00) begin
            n_fail++;
            $display("FAIL rig_reset: valid=%b ptr=%0d onehot=%h, want 0/0/00", grant_valid, ptr, grant_onehot);
        end
        tick(8'hFF, 1'b0, 1'b0);
        n_tests++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL rig_regrant: valid=%b idx=%0d, want 1/0", grant_valid, grant_idx);
        end
    endtask

    // Random requesters that hold until granted; random ready and rare resets.
    task automatic test_random;
        logic [W-1:0] pend;
        logic [W-1:0] r;
        logic [W-1:0] exp_oh;
        logic         rdy;
        logic         rst;
        logic         hs;
        int           acc;
        pend = 8'hFF;   // everyone in flight from the previous test stays pending
        for (int c = 0; c < 400; c++) begin
            pend = pend | (8'($urandom) & 8'($urandom) & 8'($urandom));
            rdy  = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 63) == 0);
            r    = pend;
            hs   = m_valid && rdy && !rst;
            acc  = m_idx;
            if (hs && ($urandom_range(0, 1) == 1)) begin
                r[acc]    = 1'b0;
                pend[acc] = 1'b0;
            end
            tick(r, rdy, rst);
            if (hs && !(m_valid && m_idx == acc)) pend[acc] = 1'b0;
            exp_oh = m_valid ? (8'(1) << m_idx) : 8'h00;
            n_tests++;
            if (grant_valid !== m_valid || grant_idx !== 3'(m_idx) || grant_onehot !== exp_oh || ptr !== 3'(m_ptr)) begin
                n_fail++;
                $display("FAIL random cyc%0d: valid=%b idx=%0d onehot=%h ptr=%0d, want %b/%0d/%h/%0d",
                         c, grant_valid, grant_idx, grant_onehot, ptr, m_valid, m_idx, exp_oh, m_ptr);
            end
            n_tests++;
            if (!$onehot0(grant_onehot) || grant_valid !== (|grant_onehot)) begin
                n_fail++;
                $display("FAIL invariant cyc%0d: valid=%b onehot=%h, want onehot0 and valid==|onehot",
                         c, grant_valid, grant_onehot);
            end
        end
    endtask

    initial begin
        test_reset();
`ifndef FFO_FIXED_PRIO_EN
        test_back_to_back();
        test_skip_wrap();
        test_stall();
        test_drain_idle();
`else
        test_fixed_prio();
`endif
        test_reset_in_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
